// File: rtl/mc_cpu.sv
// Multi-cycle MIPS-subset core: one shared ALU, one unified memory port with a req/ready handshake.
// Halts on an all-zero instruction and counts retired instructions.
module mc_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic             halt,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] S_BOOT = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
                         OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADDU = 6'h21,
                         F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

  logic [2:0]  state;
  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] rf [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] sext, zext, alu_res, br_target, wb_data;
  logic        br_taken, is_jr, wb_en;
  logic [4:0]  wb_sel;
  logic [CNT_W-1:0] cnt_one;

  assign op        = ir[31:26];
  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign shamt     = ir[10:6];
  assign funct     = ir[5:0];
  assign sext      = {{16{ir[15]}}, ir[15:0]};
  assign zext      = {16'h0000, ir[15:0]};
  assign is_jr     = (op == OP_R) && (funct == F_JR);
  assign br_taken  = ((op == OP_BEQ) && (a == b)) || ((op == OP_BNE) && (a != b));
  // pc already holds PC+4 by the time a branch executes
  assign br_target = pc + {sext[29:0], 2'b00};
  assign cnt_one   = CNT_W'(1);

  always_comb begin
    alu_res = 32'h0;
    case (op)
      OP_R: begin
        case (funct)
          F_ADDU:  alu_res = a + b;
          F_SUBU:  alu_res = a - b;
          F_AND:   alu_res = a & b;
          F_OR:    alu_res = a | b;
          F_SLT:   alu_res = {31'h0, $signed(a) < $signed(b)};
          F_SLL:   alu_res = b << shamt;
          F_SRL:   alu_res = b >> shamt;
          default: alu_res = 32'h0;
        endcase
      end
      OP_ADDIU, OP_LW, OP_SW: alu_res = a + sext;
      OP_SLTI: alu_res = {31'h0, $signed(a) < $signed(sext)};
      OP_ANDI: alu_res = a & zext;
      OP_ORI:  alu_res = a | zext;
      OP_LUI:  alu_res = {ir[15:0], 16'h0000};
      default: alu_res = 32'h0;
    endcase
  end

  // unsupported encodings reach WB with wb_en low, so they retire as NOPs
  always_comb begin
    wb_en   = 1'b0;
    wb_sel  = rd;
    wb_data = alu_out;
    case (op)
      OP_R: begin
        case (funct)
          F_ADDU, F_SUBU, F_AND, F_OR, F_SLT, F_SLL, F_SRL: wb_en = 1'b1;
          default: wb_en = 1'b0;
        endcase
      end
      OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
        wb_en  = 1'b1;
        wb_sel = rt;
      end
      OP_LW: begin
        wb_en   = 1'b1;
        wb_sel  = rt;
        wb_data = mdr;
      end
      default: wb_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_BOOT;
      pc      <= RESET_PC;
      ir      <= 32'h0;
      a       <= 32'h0;
      b       <= 32'h0;
      alu_out <= 32'h0;
      mdr     <= 32'h0;
      instret <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else begin
      case (state)
        S_BOOT: state <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata;
            pc    <= pc + 32'd4;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a <= rf[rs];
          b <= rf[rt];
          if (ir == 32'h0) begin
            state <= S_HALT;
          end else if ((op == OP_J) || (op == OP_JAL)) begin
            pc      <= {pc[31:28], ir[25:0], 2'b00};
            if (op == OP_JAL) rf[31] <= pc;
            instret <= instret + cnt_one;
            state   <= S_FETCH;
          end else if (is_jr) begin
            pc      <= rf[rs];
            instret <= instret + cnt_one;
            state   <= S_FETCH;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_out <= alu_res;
          if ((op == OP_BEQ) || (op == OP_BNE)) begin
            if (br_taken) pc <= br_target;
            instret <= instret + cnt_one;
            state   <= S_FETCH;
          end else if ((op == OP_LW) || (op == OP_SW)) begin
            state <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (op == OP_SW) begin
              instret <= instret + cnt_one;
              state   <= S_FETCH;
            end else begin
              mdr   <= mem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (wb_en && (wb_sel != 5'd0)) rf[wb_sel] <= wb_data;
          instret <= instret + cnt_one;
          state   <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_BOOT;
      endcase
    end
  end

  assign mem_req   = (state == S_FETCH) || (state == S_MEM);
  assign mem_we    = (state == S_MEM) && (op == OP_SW);
  assign mem_addr  = (state == S_FETCH) ? {pc[31:2], 2'b00} :
                     (state == S_MEM)   ? {alu_out[31:2], 2'b00} : 32'h0;
  assign mem_wdata = mem_we ? b : 32'h0;
  assign halt      = (state == S_HALT);

endmodule

// File: tb/tb_mc_cpu.sv
// Directed bench for mc_cpu: table of small programs plus hand sequences for stalls, reset and wrap.
// Instruction image and store data live in separate arrays so only one process writes each.
module tb_mc_cpu;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        mem_req, mem_we, mem_ready, halt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, instret;
  logic        mem2_req, mem2_we, halt2;
  logic [31:0] mem2_addr, mem2_wdata, mem2_rdata;
  logic [1:0]  instret2;

  logic [31:0]  imem [256];
  logic [31:0]  dmem [256];
  logic [255:0] dvalid;
  logic [31:0]  img2 [256];

  logic ready_fixed, ready_rand, rnd_ready;
  int   total = 0, bad = 0;
  int   stab_n = 0, stab_bad = 0;

  always #5 clk = ~clk;

  assign mem_ready  = ready_rand ? rnd_ready : ready_fixed;
  assign mem_rdata  = dvalid[mem_addr[9:2]] ? dmem[mem_addr[9:2]] : imem[mem_addr[9:2]];
  assign mem2_rdata = img2[mem2_addr[9:2]];

  mc_cpu dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halt(halt), .instret(instret)
  );

  mc_cpu #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .mem_req(mem2_req), .mem_we(mem2_we), .mem_addr(mem2_addr),
    .mem_wdata(mem2_wdata), .mem_rdata(mem2_rdata), .mem_ready(1'b1),
    .halt(halt2), .instret(instret2)
  );

  // store side of the memory model; reset wipes previously stored data
  initial begin
    logic wr;
    logic [7:0] wa;
    logic [31:0] wd;
    dvalid = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) dvalid = '0;
      wr = mem_req && mem_ready && mem_we;
      wa = mem_addr[9:2];
      wd = mem_wdata;
      @(posedge clk);
      if (wr && !rst) begin
        dmem[wa]   = wd;
        dvalid[wa] = 1'b1;
      end
    end
  end

  // random 0..5 cycle stall before each request completes
  initial begin
    int stall_left;
    stall_left = 2;
    rnd_ready  = 1'b1;
    forever begin
      @(negedge clk); #1;
      if (mem_req && mem_ready) stall_left = $urandom_range(0, 5);
      @(posedge clk); #1;
      if (mem_req && stall_left > 0) begin
        rnd_ready  = 1'b0;
        stall_left = stall_left - 1;
      end else begin
        rnd_ready = 1'b1;
      end
    end
  end

  // a stalled request must keep address, direction and data unchanged
  initial begin
    logic stall_prev, swe;
    logic [31:0] sa, sd;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (stall_prev && mem_req && !rst) begin
        stab_n++;
        if (mem_addr !== sa || mem_we !== swe || mem_wdata !== sd) stab_bad++;
      end
      stall_prev = mem_req && !mem_ready;
      sa  = mem_addr;
      swe = mem_we;
      sd  = mem_wdata;
    end
  end

  function automatic logic [31:0] ii(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rr(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [4:0] sh, logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] jj(logic [5:0] op, logic [25:0] t);
    return {op, t};
  endfunction

  function automatic logic [31:0] rdmem(int idx);
    return dvalid[idx] ? dmem[idx] : imem[idx];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_to_halt(output int cyc);
    cyc = 0;
    while (!halt && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (!halt) begin
      total++;
      bad++;
      $display("FAIL halt_timeout: got no halt after %0d cycles want halt", cyc);
    end
  endtask

  typedef struct {
    logic [19:0][31:0] prog;
    logic [4:0]        rnum;
    logic [31:0]       exp_val;
    logic [31:0]       exp_pc;
    logic [31:0]       exp_ret;
    string             name;
  } vec_t;

  vec_t vecs[17];

  task automatic mk(input int k, input string nm, input logic [4:0] r, input logic [31:0] v,
                    input logic [31:0] p, input logic [31:0] n);
    vecs[k].prog    = '0;
    vecs[k].name    = nm;
    vecs[k].rnum    = r;
    vecs[k].exp_val = v;
    vecs[k].exp_pc  = p;
    vecs[k].exp_ret = n;
  endtask

  task automatic load_prog(input int k);
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    for (int i = 0; i < 20; i++) imem[i] = vecs[k].prog[i];
  endtask

  initial begin
    int cyc, reqs;
    logic [31:0] pc_hold;

    rst = 1'b1; rst2 = 1'b1;
    ready_fixed = 1'b1; ready_rand = 1'b0;
    for (int i = 0; i < 256; i++) begin
      img2[i] = 32'h0;
      dmem[i] = 32'h0;
    end
    for (int i = 0; i < 5; i++) img2[i] = 32'hFC00_0000;

    mk(0, "basic", 5'd4, 32'h2, 32'h18, 5);
    vecs[0].prog[0] = ii(6'h09, 5'd0, 5'd1, 16'd5);
    vecs[0].prog[1] = ii(6'h09, 5'd0, 5'd2, 16'hFFFD);
    vecs[0].prog[2] = rr(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
    vecs[0].prog[3] = ii(6'h2B, 5'd0, 5'd3, 16'h0080);
    vecs[0].prog[4] = ii(6'h23, 5'd0, 5'd4, 16'h0080);
    mk(1, "and", 5'd3, 32'h8, 32'h10, 3);
    vecs[1].prog[0] = ii(6'h09, 5'd0, 5'd1, 16'd12);
    vecs[1].prog[1] = ii(6'h09, 5'd0, 5'd2, 16'd10);
    vecs[1].prog[2] = rr(5'd1, 5'd2, 5'd3, 5'd0, 6'h24);
    mk(2, "or", 5'd3, 32'hE, 32'h10, 3);
    vecs[2].prog = vecs[1].prog;
    vecs[2].prog[2] = rr(5'd1, 5'd2, 5'd3, 5'd0, 6'h25);
    mk(3, "subu", 5'd3, 32'hFFFF_FFFE, 32'h10, 3);
    vecs[3].prog = vecs[1].prog;
    vecs[3].prog[2] = rr(5'd2, 5'd1, 5'd3, 5'd0, 6'h23);
    mk(4, "slt_neg", 5'd3, 32'h1, 32'h10, 3);
    vecs[4].prog[0] = ii(6'h0F, 5'd0, 5'd1, 16'h8000);
    vecs[4].prog[1] = ii(6'h09, 5'd0, 5'd2, 16'd1);
    vecs[4].prog[2] = rr(5'd1, 5'd2, 5'd3, 5'd0, 6'h2A);
    mk(5, "lui_ori", 5'd1, 32'hABCD_FFFF, 32'h0C, 2);
    vecs[5].prog[0] = ii(6'h0F, 5'd0, 5'd1, 16'hABCD);
    vecs[5].prog[1] = ii(6'h0D, 5'd1, 5'd1, 16'hFFFF);
    mk(6, "sll31", 5'd2, 32'h8000_0000, 32'h0C, 2);
    vecs[6].prog[0] = ii(6'h09, 5'd0, 5'd1, 16'd3);
    vecs[6].prog[1] = rr(5'd0, 5'd1, 5'd2, 5'd31, 6'h00);
    mk(7, "srl4", 5'd2, 32'h0FFF_FFFF, 32'h0C, 2);
    vecs[7].prog[0] = ii(6'h09, 5'd0, 5'd1, 16'hFFFF);
    vecs[7].prog[1] = rr(5'd0, 5'd1, 5'd2, 5'd4, 6'h02);
    mk(8, "slti", 5'd2, 32'h1, 32'h0C, 2);
    vecs[8].prog[0] = ii(6'h09, 5'd0, 5'd1, 16'hFFFB);
    vecs[8].prog[1] = ii(6'h0A, 5'd1, 5'd2, 16'hFFFC);
    mk(9, "andi_zext", 5'd2, 32'h0000_8001, 32'h0C, 2);
    vecs[9].prog[0] = ii(6'h09, 5'd0, 5'd1, 16'hFFFF);
    vecs[9].prog[1] = ii(6'h0C, 5'd1, 5'd2, 16'h8001);
    mk(10, "r0_write", 5'd1, 32'h1, 32'h0C, 2);
    vecs[10].prog[0] = ii(6'h09, 5'd0, 5'd0, 16'd7);
    vecs[10].prog[1] = ii(6'h09, 5'd0, 5'd1, 16'd1);
    mk(11, "beq_taken", 5'd3, 32'h4, 32'h14, 3);
    vecs[11].prog[0] = ii(6'h09, 5'd0, 5'd1, 16'd1);
    vecs[11].prog[1] = ii(6'h04, 5'd1, 5'd1, 16'd1);
    vecs[11].prog[2] = ii(6'h09, 5'd0, 5'd2, 16'd9);
    vecs[11].prog[3] = ii(6'h09, 5'd0, 5'd3, 16'd4);
    mk(12, "bne_not", 5'd2, 32'h9, 32'h10, 3);
    vecs[12].prog[0] = ii(6'h09, 5'd0, 5'd1, 16'd1);
    vecs[12].prog[1] = ii(6'h05, 5'd1, 5'd1, 16'd1);
    vecs[12].prog[2] = ii(6'h09, 5'd0, 5'd2, 16'd9);
    mk(13, "jal_jr", 5'd31, 32'h4, 32'h0C, 3);
    vecs[13].prog[0]  = jj(6'h03, 26'h10);
    vecs[13].prog[1]  = ii(6'h09, 5'd0, 5'd5, 16'd7);
    vecs[13].prog[16] = rr(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
    mk(14, "lw_unaligned", 5'd2, 32'h1234_5678, 32'h0C, 2);
    vecs[14].prog[0] = ii(6'h09, 5'd0, 5'd1, 16'h0013);
    vecs[14].prog[1] = ii(6'h23, 5'd1, 5'd2, 16'h0000);
    vecs[14].prog[4] = 32'h1234_5678;
    mk(15, "unsupported", 5'd1, 32'h3, 32'h10, 3);
    vecs[15].prog[0] = ii(6'h09, 5'd0, 5'd1, 16'd3);
    vecs[15].prog[1] = 32'hFC00_0000;
    vecs[15].prog[2] = rr(5'd0, 5'd0, 5'd1, 5'd0, 6'h3F);
    mk(16, "j", 5'd2, 32'h5, 32'h14, 2);
    vecs[16].prog[0] = jj(6'h02, 26'h3);
    vecs[16].prog[1] = ii(6'h09, 5'd0, 5'd2, 16'd9);
    vecs[16].prog[3] = ii(6'h09, 5'd0, 5'd2, 16'd5);

    // reset values, first-fetch latency and zero-wait cycle count
    load_prog(0);
    @(negedge clk); #1;
    chk("reset_outputs", {28'h0, mem_req, mem_we, halt, 1'b0}, 32'h0);
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_wdata", mem_wdata, 32'h0);
    chk("reset_instret", instret, 32'h0);
    chk("reset_pc", dut.pc, 32'h0);
    @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;
    #1 chk("boot_no_req", {31'h0, mem_req}, 32'h0);
    @(negedge clk);
    chk("first_req", {31'h0, mem_req}, 32'h1);
    chk("first_addr", mem_addr, 32'h0);
    run_to_halt(cyc);
    // 4+4+4+4+5 for the program, then FETCH+DECODE of the zero word
    chk("basic_cycles", cyc, 32'd23);
    chk("basic_mem80", rdmem(32), 32'h2);

    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      rst = 1'b1;
      load_prog(k);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_to_halt(cyc);
      chk({vecs[k].name, ".reg"}, dut.rf[vecs[k].rnum], vecs[k].exp_val);
      chk({vecs[k].name, ".pc"}, dut.pc, vecs[k].exp_pc);
      chk({vecs[k].name, ".instret"}, instret, vecs[k].exp_ret);
      chk({vecs[k].name, ".r0"}, dut.rf[0], 32'h0);
    end

    // same basic program under random stalls
    @(negedge clk);
    rst = 1'b1;
    load_prog(0);
    ready_rand = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_to_halt(cyc);
    ready_rand = 1'b0;
    chk("stall.r4", dut.rf[4], 32'h2);
    chk("stall.mem80", rdmem(32), 32'h2);
    chk("stall.instret", instret, 32'd5);
    chk("stall.stable_bad", stab_bad, 32'd0);
    chk("stall.seen", {31'h0, stab_n > 0}, 32'h1);

    // reset during a stalled store
    for (int i = 0; i < 20; i++) vecs[0].prog[i] = 32'h0;
    vecs[0].prog[0] = ii(6'h09, 5'd0, 5'd1, 16'd5);
    vecs[0].prog[1] = ii(6'h2B, 5'd0, 5'd1, 16'h0080);
    @(negedge clk);
    rst = 1'b1;
    load_prog(0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    while (!(mem_req && mem_we) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("sw_reached", {31'h0, mem_req && mem_we}, 32'h1);
    ready_fixed = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst.req", {31'h0, mem_req}, 32'h0);
    chk("rst.pc", dut.pc, 32'h0);
    chk("rst.instret", instret, 32'h0);
    chk("rst.r1", dut.rf[1], 32'h0);
    chk("rst.nowrite", {31'h0, dvalid[32]}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ready_fixed = 1'b1;
    run_to_halt(cyc);
    chk("rerun.mem80", rdmem(32), 32'h5);
    chk("rerun.instret", instret, 32'd2);

    // HALT ignores mem_ready and freezes state
    pc_hold = dut.pc;
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      ready_fixed = ~ready_fixed;
      @(negedge clk);
      if (mem_req) reqs++;
    end
    chk("halt.reqs", reqs, 32'd0);
    chk("halt.instret", instret, 32'd2);
    chk("halt.pc", dut.pc, 32'h0C);
    chk("halt.pc_frozen", dut.pc, pc_hold);
    chk("halt.flag", {31'h0, halt}, 32'h1);

    // five NOPs then halt on a 2-bit counter
    chk("wrap.halt", {31'h0, halt2}, 32'h1);
    chk("wrap.instret", {30'h0, instret2}, 32'h1);
    chk("wrap.idle", {30'h0, mem2_req, mem2_we}, 32'h0);
    chk("wrap.wdata", mem2_wdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
